// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: a four-state fetch/execute sequencer. It owns the program
// counter, the instruction register and the address-bus mux select. Every
// output comes from a flop, so no input reaches an output combinationally.
module pc_fetch_ctrl #(
    parameter logic [7:0] RESET_VECTOR = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic [31:0] instr_in,
    input  logic        data_access_req,
    input  logic        branch_en,
    input  logic [7:0]  branch_target,
    input  logic        halt,
    output logic [7:0]  pc_address,
    output logic        select,
    output logic [31:0] instr_reg,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DATA  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  pc_next;
    logic [31:0] instr_next;
    logic        pending_flag;
    logic        pending_flag_next;
    logic [7:0]  pending_target;
    logic [7:0]  pending_target_next;

    // Next-state logic. The flag-style outputs are derived from the state we
    // are about to enter, which keeps them registered and aligned with it.
    always_comb begin
        state_next          = state;
        pc_next             = pc_address;
        instr_next          = instr_reg;
        pending_flag_next   = pending_flag;
        pending_target_next = pending_target;

        unique case (state)
            FETCH: begin
                if (mem_ready) begin
                    instr_next = instr_in;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (halt) begin
                    state_next = HALT;
                end else if (data_access_req) begin
                    state_next = DATA;
                    // A branch that arrives with a data access is deferred
                    // until the access completes.
                    if (branch_en) begin
                        pending_flag_next   = 1'b1;
                        pending_target_next = branch_target;
                    end
                end else if (branch_en) begin
                    pc_next    = branch_target;
                    state_next = FETCH;
                end else begin
                    pc_next    = pc_address + 8'd1;
                    state_next = FETCH;
                end
            end
            DATA: begin
                if (mem_ready) begin
                    if (pending_flag) begin
                        pc_next           = pending_target;
                        pending_flag_next = 1'b0;
                    end else begin
                        pc_next = pc_address + 8'd1;
                    end
                    state_next = FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FETCH;
            pc_address     <= RESET_VECTOR;
            select         <= 1'b0;
            instr_reg      <= 32'h0;
            instr_valid    <= 1'b0;
            halted         <= 1'b0;
            pending_flag   <= 1'b0;
            pending_target <= 8'h0;
        end else begin
            state          <= state_next;
            pc_address     <= pc_next;
            select         <= (state_next == DATA);
            instr_reg      <= instr_next;
            instr_valid    <= (state_next == EXEC);
            halted         <= (state_next == HALT);
            pending_flag   <= pending_flag_next;
            pending_target <= pending_target_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios for pc_fetch_ctrl. Inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_ready;
    logic [31:0] instr_in;
    logic        data_access_req;
    logic        branch_en;
    logic [7:0]  branch_target;
    logic        halt;
    logic [7:0]  pc_address;
    logic        select;
    logic [31:0] instr_reg;
    logic        instr_valid;
    logic        halted;

    int vectors;
    int miscompares;

    pc_fetch_ctrl #(.RESET_VECTOR(8'd0)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_ready       (mem_ready),
        .instr_in        (instr_in),
        .data_access_req (data_access_req),
        .branch_en       (branch_en),
        .branch_target   (branch_target),
        .halt            (halt),
        .pc_address      (pc_address),
        .select          (select),
        .instr_reg       (instr_reg),
        .instr_valid     (instr_valid),
        .halted          (halted)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_ready       = 1'b0;
        instr_in        = 32'h0;
        data_access_req = 1'b0;
        branch_en       = 1'b0;
        branch_target   = 8'h0;
        halt            = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Reset, then branch to 'pc' and fetch there, leaving the DUT in EXEC at
    // 'pc' with instr_reg = 32'h1111_0000 | pc and mem_ready still high.
    task automatic goto_exec_at(input logic [7:0] pc);
        do_reset();
        mem_ready = 1'b1;
        instr_in  = 32'h1111_0000 | {24'h0, pc};
        tick();
        branch_en     = 1'b1;
        branch_target = pc;
        tick();
        branch_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({pc_address, select, instr_valid, halted, instr_reg} !== {8'h00, 3'b000, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got pc=%h sel=%b v=%b h=%b ir=%h, want pc=00 sel=0 v=0 h=0 ir=00000000",
                     pc_address, select, instr_valid, halted, instr_reg);
        end
    endtask

    task automatic test_sequential();
        logic [7:0] exp_pc;
        logic       exp_v;
        do_reset();
        mem_ready = 1'b1;
        instr_in  = 32'hA5A5_0001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_pc = 8'(k / 2);
            exp_v  = (k % 2) == 1;
            vectors++;
            if ({pc_address, select, instr_valid, halted, instr_reg} !== {exp_pc, 1'b0, exp_v, 1'b0, 32'hA5A5_0001}) begin
                miscompares++;
                $display("[TB] FAIL sequential[%0d]: got pc=%h sel=%b v=%b h=%b ir=%h, want pc=%h sel=0 v=%b h=0 ir=a5a50001",
                         k, pc_address, select, instr_valid, halted, instr_reg, exp_pc, exp_v);
            end
        end
    endtask

    task automatic test_data_access();
        goto_exec_at(8'h05);
        data_access_req = 1'b1;
        mem_ready       = 1'b0;
        tick();
        data_access_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({pc_address, select, instr_valid} !== {8'h05, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL data_hold[%0d]: got pc=%h sel=%b v=%b, want pc=05 sel=1 v=0",
                         i, pc_address, select, instr_valid);
            end
            mem_ready = (i == 3);
            tick();
        end
        vectors++;
        if ({pc_address, select, instr_valid} !== {8'h06, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL data_done: got pc=%h sel=%b v=%b, want pc=06 sel=0 v=0",
                     pc_address, select, instr_valid);
        end
        tick();
        vectors++;
        if ({pc_address, select, instr_valid} !== {8'h06, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL data_refetch: got pc=%h sel=%b v=%b, want pc=06 sel=0 v=1",
                     pc_address, select, instr_valid);
        end
    endtask

    task automatic test_branch();
        do_reset();
        mem_ready = 1'b1;
        tick();
        branch_en     = 1'b1;
        branch_target = 8'h40;
        tick();
        branch_en     = 1'b0;
        branch_target = 8'h99;
        vectors++;
        if ({pc_address, select, instr_valid} !== {8'h40, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL branch_pc: got pc=%h sel=%b v=%b, want pc=40 sel=0 v=0",
                     pc_address, select, instr_valid);
        end
        tick();
        vectors++;
        if ({pc_address, select, instr_valid} !== {8'h40, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL branch_exec: got pc=%h sel=%b v=%b, want pc=40 sel=0 v=1",
                     pc_address, select, instr_valid);
        end
    endtask

    task automatic test_wrap();
        goto_exec_at(8'hFF);
        tick();
        vectors++;
        if ({pc_address, select} !== {8'h00, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wrap_default: got pc=%h sel=%b, want pc=00 sel=0", pc_address, select);
        end
        goto_exec_at(8'hFF);
        data_access_req = 1'b1;
        tick();
        data_access_req = 1'b0;
        vectors++;
        if ({pc_address, select} !== {8'hFF, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL wrap_data_enter: got pc=%h sel=%b, want pc=ff sel=1", pc_address, select);
        end
        tick();
        vectors++;
        if ({pc_address, select} !== {8'h00, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wrap_data_exit: got pc=%h sel=%b, want pc=00 sel=0", pc_address, select);
        end
    endtask

    task automatic test_pending_branch();
        goto_exec_at(8'h20);
        data_access_req = 1'b1;
        branch_en       = 1'b1;
        branch_target   = 8'h10;
        mem_ready       = 1'b0;
        tick();
        data_access_req = 1'b0;
        branch_en       = 1'b0;
        branch_target   = 8'h55;
        vectors++;
        if ({pc_address, select} !== {8'h20, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL pending_data: got pc=%h sel=%b, want pc=20 sel=1", pc_address, select);
        end
        tick();
        mem_ready = 1'b1;
        tick();
        vectors++;
        if ({pc_address, select} !== {8'h10, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL pending_taken: got pc=%h sel=%b, want pc=10 sel=0", pc_address, select);
        end
        // A plain data access next must increment, proving the flag cleared.
        tick();
        data_access_req = 1'b1;
        tick();
        data_access_req = 1'b0;
        tick();
        vectors++;
        if ({pc_address, select} !== {8'h11, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL pending_cleared: got pc=%h sel=%b, want pc=11 sel=0", pc_address, select);
        end
    endtask

    task automatic test_halt();
        goto_exec_at(8'h33);
        halt            = 1'b1;
        data_access_req = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({pc_address, select, instr_valid, halted, instr_reg} !== {8'h33, 1'b0, 1'b0, 1'b1, 32'h1111_0033}) begin
                miscompares++;
                $display("[TB] FAIL halt_frozen[%0d]: got pc=%h sel=%b v=%b h=%b ir=%h, want pc=33 sel=0 v=0 h=1 ir=11110033",
                         i, pc_address, select, instr_valid, halted, instr_reg);
            end
            mem_ready       = i[0];
            halt            = i[1];
            data_access_req = i[0];
            branch_en       = ~i[0];
            branch_target   = 8'hC0;
            instr_in        = 32'hDEAD_0000 + i;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        vectors++;
        if ({pc_address, select, instr_valid, halted} !== {8'h00, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL halt_reset: got pc=%h sel=%b v=%b h=%b, want pc=00 sel=0 v=0 h=0",
                     pc_address, select, instr_valid, halted);
        end
    endtask

    task automatic test_reset_in_data();
        goto_exec_at(8'h77);
        data_access_req = 1'b1;
        branch_en       = 1'b1;
        branch_target   = 8'h3C;
        mem_ready       = 1'b0;
        tick();
        data_access_req = 1'b0;
        branch_en       = 1'b0;
        reset           = 1'b1;
        mem_ready       = 1'b1;
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        vectors++;
        if ({pc_address, select, instr_valid, halted, instr_reg} !== {8'h00, 3'b000, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL reset_in_data: got pc=%h sel=%b v=%b h=%b ir=%h, want pc=00 sel=0 v=0 h=0 ir=00000000",
                     pc_address, select, instr_valid, halted, instr_reg);
        end
        // The deferred branch must not survive reset: a plain access increments.
        mem_ready = 1'b1;
        tick();
        data_access_req = 1'b1;
        tick();
        data_access_req = 1'b0;
        tick();
        vectors++;
        if ({pc_address, select} !== {8'h01, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_clears_pending: got pc=%h sel=%b, want pc=01 sel=0", pc_address, select);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_data_access();
        test_branch();
        test_wrap();
        test_pending_branch();
        test_halt();
        test_reset_in_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 8'd0, the PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_ready  input  1  memory has completed the current access this cycle.
REQ-005 instr_in  input  32  instruction word from the memory data bus, valid when mem_ready=1 during fetch.
REQ-006 data_access_req  input  1  the execute stage requests a data-memory access; sampled in EXEC only.
REQ-007 branch_en  input  1  take a branch; sampled in EXEC only.
REQ-008 branch_target  input  8  branch destination; sampled with branch_en.
REQ-009 halt  input  1  stop fetching; sampled in EXEC only.
REQ-010 pc_address  output  8  registered program counter; feeds the address-bus mux PC input.
REQ-011 select  output  1  registered address-bus mux select: 0 = PC drives the address bus, 1 = data access drives it.
REQ-012 instr_reg  output  32  registered copy of the last fetched instruction.
REQ-013 instr_valid  output  1  registered; high for exactly the one EXEC cycle after a fetch completes.
REQ-014 halted  output  1  registered; high while in HALT.

Function
REQ-015 The FSM SHALL have four states: FETCH, EXEC, DATA, HALT.
REQ-016 FETCH: select=0; if mem_ready=1, instr_reg<=instr_in and go to EXEC; otherwise hold pc_address and stay.
REQ-017 EXEC: lasts exactly one cycle; instr_valid=1; mem_ready is ignored.
REQ-018 EXEC priority 1: halt=1 goes to HALT with pc_address unchanged.
REQ-019 EXEC priority 2: data_access_req=1 goes to DATA with select=1 from the next cycle and pc_address held.
REQ-020 EXEC priority 3: branch_en=1 sets pc_address<=branch_target and goes to FETCH.
REQ-021 EXEC default: pc_address<=pc_address+1 modulo 256 (8'hFF wraps to 8'h00) and go to FETCH.
REQ-022 EXEC with data_access_req=1 and branch_en=1 SHALL latch branch_target into a pending-branch register and set a pending flag.
REQ-023 DATA: select=1 and pc_address held until mem_ready=1. Then:
- with pending flag set: pc_address<=pending target and the flag clears;
- otherwise: pc_address<=pc_address+1 modulo 256;
- in both cases: go to FETCH with select=0 from the next cycle.
REQ-024 HALT: halted=1, select=0, pc_address frozen; all inputs except reset are ignored; exit is by reset only.
REQ-025 select SHALL equal 1 exactly in the cycles the FSM is in DATA; it is registered with no combinational input-to-output path.
REQ-026 instr_valid SHALL be 0 in FETCH, DATA and HALT.
REQ-027 When mem_ready is held at 1, minimum latency is 2 cycles per instruction (FETCH+EXEC), or 3 with a data access.

Reset
REQ-028 reset=1 at a rising edge SHALL, regardless of state (including mid-DATA or HALT), set:
- state=FETCH, pc_address=RESET_VECTOR, select=0;
- instr_reg=32'h0, instr_valid=0, halted=0;
- pending flag cleared, pending target=8'h0.
REQ-029 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-030 Reset, then mem_ready=1 constant, instr_in=32'hA5A5_0001, no requests -> pc_address 0,0,1,1,2,...; instr_valid pulses every 2nd cycle; instr_reg=32'hA5A5_0001; select stays 0.
REQ-031 data_access_req=1 in EXEC at pc 8'h05, mem_ready low 3 cycles then high -> select=1 for 4 cycles, pc_address holds 8'h05, then becomes 8'h06 with select=0.
REQ-032 branch_en=1, branch_target=8'h40 in EXEC -> next pc_address=8'h40, next instr_valid 2 cycles later (mem_ready=1).
REQ-033 PC at 8'hFF, default EXEC -> pc_address=8'h00; a data access at 8'hFF likewise wraps to 8'h00.
REQ-034 data_access_req=1 and branch_en=1 (target 8'h10) in the same EXEC -> DATA first (select=1), then pc_address=8'h10 and the pending flag cleared.
REQ-035 halt=1 in EXEC -> halted=1, pc_address frozen for 10 cycles despite mem_ready toggling; separately, reset asserted during DATA -> next cycle select=0, pc_address=RESET_VECTOR, halted=0.
